// File: rtl/charmatrix_pkg.sv
// Shared types and byte-command constants for the char-matrix engine.
package charmatrix_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWaitReady,
    StWaitStarted
  } state_e;

  localparam logic [7:0] CMD_CLEAR    = 8'h0C;
  localparam logic [7:0] CMD_BS       = 8'h08;
  localparam logic [7:0] CMD_COLOR_LO = 8'h10;
  localparam logic [7:0] CMD_COLOR_HI = 8'h1F;
  localparam logic [7:0] PRINT_LO     = 8'h20;
  localparam logic [7:0] PRINT_HI     = 8'h7E;
  localparam logic [7:0] BLANK_CHAR   = 8'h20;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

  function automatic logic is_color(input logic [7:0] b);
    return (b >= CMD_COLOR_LO) && (b <= CMD_COLOR_HI);
  endfunction

endpackage

// File: rtl/charmatrix_if.sv
// Bundle of UART RX, ROM, ws2812b and status signals around the char-matrix engine.
interface charmatrix_if #(
  parameter int unsigned CHAR_LEDS = 35
);
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 refresh;
  logic                 scroll_en;
  logic [7:0]           char_index;
  logic [CHAR_LEDS-1:0] char_data;
  logic [3:0]           color_index;
  logic [23:0]          color_data;
  logic [23:0]          led_data;
  logic                 led_valid;
  logic                 led_latch;
  logic                 led_ready;
  logic                 busy;
  logic                 overflow;

  modport master (
    output rx_data, rx_valid, refresh, scroll_en, char_data, color_data, led_ready,
    input  rx_ready, char_index, color_index, led_data, led_valid, led_latch, busy, overflow
  );

  modport slave (
    input  rx_data, rx_valid, refresh, scroll_en, char_data, color_data, led_ready,
    output rx_ready, char_index, color_index, led_data, led_valid, led_latch, busy, overflow
  );
endinterface

// File: rtl/charmatrix_textbuf.sv
// Text buffer: decodes the RX byte stream into characters, colour and edit commands.
module charmatrix_textbuf
  import charmatrix_pkg::*;
#(
  parameter int unsigned BUF_CHARS = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   rx_data,
  input  logic                         rx_valid,
  output logic                         rx_ready,
  input  logic [$clog2(BUF_CHARS)-1:0] rd_addr,
  output logic [7:0]                   rd_char,
  output logic [3:0]                   rd_col,
  output logic [$clog2(BUF_CHARS):0]   len,
  output logic                         overflow,
  output logic                         clear
);
  localparam int unsigned LW = $clog2(BUF_CHARS);
  localparam int unsigned JW = LW + 1;

  logic [7:0] mem_char [BUF_CHARS];
  logic [3:0] mem_col  [BUF_CHARS];
  logic [3:0] cur_col;
  logic       fire;
  logic       full;
  logic       wr_en;

  assign fire  = rx_valid & rx_ready;
  assign full  = (len == JW'(BUF_CHARS));
  assign wr_en = fire && is_printable(rx_data) && !full;
  assign clear = fire && (rx_data == CMD_CLEAR);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_char[len[LW-1:0]] <= rx_data;
      mem_col[len[LW-1:0]]  <= cur_col;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready <= 1'b0;
      len      <= '0;
      cur_col  <= '0;
      overflow <= 1'b0;
    end else begin
      rx_ready <= 1'b1;
      if (fire) begin
        if (is_printable(rx_data)) begin
          if (full) overflow <= 1'b1;
          else      len      <= len + JW'(1);
        end else if (is_color(rx_data)) begin
          cur_col <= rx_data[3:0];
        end else if (rx_data == CMD_CLEAR) begin
          len      <= '0;
          overflow <= 1'b0;
        end else if ((rx_data == CMD_BS) && (len != '0)) begin
          len <= len - JW'(1);
        end
      end
    end
  end

  assign rd_char = mem_char[rd_addr];
  assign rd_col  = mem_col[rd_addr];

endmodule

// File: rtl/charmatrix_engine.sv
// Renders a NUM_CHARS window of the text buffer through the char/colour ROMs into ws2812b words.
module charmatrix_engine
  import charmatrix_pkg::*;
#(
  parameter int unsigned NUM_CHARS  = 8,
  parameter int unsigned CHAR_LEDS  = 35,
  parameter int unsigned BUF_CHARS  = 32,
  parameter int unsigned SCROLL_DIV = 8
) (
  input logic         clk20,
  input logic         reset,
  charmatrix_if.slave bus
);
  localparam int unsigned JW = $clog2(BUF_CHARS) + 1;
  localparam int unsigned KW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
  localparam int unsigned PW = (CHAR_LEDS > 1) ? $clog2(CHAR_LEDS) : 1;
  localparam int unsigned SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  state_e        state;
  logic [JW-1:0] len, len_snap, base, offset, offset_inc, j;
  logic [KW-1:0] k;
  logic [PW-1:0] pix;
  logic [SW-1:0] scroll_cnt;
  logic [7:0]    rd_char, char_index;
  logic [3:0]    rd_col, color_index;
  logic [23:0]   led_data;
  logic          led_valid, led_latch, busy, overflow, rx_ready, clear;
  logic          last_pix, last_char;

  charmatrix_textbuf #(
    .BUF_CHARS(BUF_CHARS)
  ) u_buf (
    .clk      (clk20),
    .rst      (reset),
    .rx_data  (bus.rx_data),
    .rx_valid (bus.rx_valid),
    .rx_ready (rx_ready),
    .rd_addr  (j[JW-2:0]),
    .rd_char  (rd_char),
    .rd_col   (rd_col),
    .len      (len),
    .overflow (overflow),
    .clear    (clear)
  );

  // j is wide enough for base+k without wrapping, so positions past len_snap read as blank
  assign j          = base + JW'(k);
  assign offset_inc = offset + JW'(1);
  assign last_pix   = (pix == PW'(CHAR_LEDS - 1));
  assign last_char  = (k == KW'(NUM_CHARS - 1));

  always_ff @(posedge clk20 or posedge reset) begin
    if (reset) begin
      state       <= StIdle;
      len_snap    <= '0;
      base        <= '0;
      offset      <= '0;
      scroll_cnt  <= '0;
      k           <= '0;
      pix         <= '0;
      char_index  <= '0;
      color_index <= '0;
      led_data    <= '0;
      led_valid   <= 1'b0;
      led_latch   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      if (clear) offset <= '0;
      unique case (state)
        StIdle: begin
          if (bus.refresh) begin
            len_snap <= len;
            base     <= bus.scroll_en ? offset : '0;
            k        <= '0;
            pix      <= '0;
            busy     <= 1'b1;
            state    <= StFetch;
            if (bus.scroll_en) begin
              if (scroll_cnt == SW'(SCROLL_DIV - 1)) begin
                scroll_cnt <= '0;
                if (!clear) offset <= (offset_inc >= len) ? '0 : offset_inc;
              end else begin
                scroll_cnt <= scroll_cnt + SW'(1);
              end
            end
          end
        end
        StFetch: begin
          if (j < len_snap) begin
            char_index  <= rd_char;
            color_index <= rd_col;
          end else begin
            char_index  <= BLANK_CHAR;
            color_index <= '0;
          end
          state <= StLoad;
        end
        StLoad: begin
          led_data  <= bus.char_data[pix] ? bus.color_data : '0;
          led_latch <= last_pix && last_char;
          state     <= StWaitReady;
        end
        StWaitReady: begin
          if (bus.led_ready) begin
            led_valid <= 1'b1;
            state     <= StWaitStarted;
          end
        end
        StWaitStarted: begin
          if (!bus.led_ready) begin
            led_valid <= 1'b0;
            if (!last_pix) begin
              pix   <= pix + PW'(1);
              state <= StLoad;
            end else if (!last_char) begin
              pix   <= '0;
              k     <= k + KW'(1);
              state <= StFetch;
            end else begin
              busy      <= 1'b0;
              led_latch <= 1'b0;
              state     <= StIdle;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.rx_ready    = rx_ready;
  assign bus.overflow    = overflow;
  assign bus.char_index  = char_index;
  assign bus.color_index = color_index;
  assign bus.led_data    = led_data;
  assign bus.led_valid   = led_valid;
  assign bus.led_latch   = led_latch;
  assign bus.busy        = busy;

endmodule
